// File: rtl/mem_req_arbiter_n_if.sv
// Bus bundle for mem_req_arbiter_n: requester-side channels plus the single
// downstream memory port. The arbiter uses the slave view; the requesters and
// the memory model together form the master view.
interface mem_req_arbiter_n_if #(
    parameter int N_CH      = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int CH_TAG_W  = 2,
    parameter int OPC_W     = 5,
    parameter int MAX_OUTST = 4
);
    localparam int SLOT_W = $clog2(MAX_OUTST);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]          ch_req_valid;
    logic [N_CH-1:0]          ch_req_ack;
    logic [N_CH*ADDR_W-1:0]   ch_req_addr;
    logic [N_CH*DATA_W-1:0]   ch_req_store_data;
    logic [N_CH*CH_TAG_W-1:0] ch_req_tag;
    logic [N_CH*OPC_W-1:0]    ch_req_opcode;
    logic [N_CH-1:0]          ch_rsp_valid;
    logic [CH_TAG_W-1:0]      ch_rsp_tag;

    logic                     mem_req_valid;
    logic                     mem_req_ack;
    logic [ADDR_W-1:0]        mem_req_addr;
    logic [DATA_W-1:0]        mem_req_store_data;
    logic [OPC_W-1:0]         mem_req_opcode;
    logic [SLOT_W-1:0]        mem_req_tag;
    logic [CH_W-1:0]          mem_req_ch;
    logic                     mem_rsp_valid;
    logic [SLOT_W-1:0]        mem_rsp_tag;

    logic [SLOT_W:0]          outstanding;
    logic                     idle;
    logic                     rsp_err;

    modport slave (
        input  ch_req_valid, ch_req_addr, ch_req_store_data, ch_req_tag, ch_req_opcode,
        input  mem_req_ack, mem_rsp_valid, mem_rsp_tag,
        output ch_req_ack, ch_rsp_valid, ch_rsp_tag,
        output mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_opcode,
        output mem_req_tag, mem_req_ch, outstanding, idle, rsp_err
    );

    modport master (
        output ch_req_valid, ch_req_addr, ch_req_store_data, ch_req_tag, ch_req_opcode,
        output mem_req_ack, mem_rsp_valid, mem_rsp_tag,
        input  ch_req_ack, ch_rsp_valid, ch_rsp_tag,
        input  mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_opcode,
        input  mem_req_tag, mem_req_ch, outstanding, idle, rsp_err
    );
endinterface

// File: rtl/mem_req_arbiter_n.sv
// N-channel round-robin arbiter merging cache-line requests onto one memory
// port. Each grant takes the lowest free in-flight slot; the slot remembers
// the source channel and requester tag so responses can be routed back.
// Grants and response routing are suppressed while reset is asserted so no
// handshake completes in a cycle whose state is being discarded.
module mem_req_arbiter_n #(
    parameter int N_CH      = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int CH_TAG_W  = 2,
    parameter int OPC_W     = 5,
    parameter int MAX_OUTST = 4
) (
    input  logic clk,
    input  logic reset,
    mem_req_arbiter_n_if.slave bus
);
    localparam int SLOT_W = $clog2(MAX_OUTST);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_W:0]   N_CH_V   = (CH_W+1)'(N_CH);
    localparam logic [CH_W-1:0] LAST_RST = CH_W'(N_CH - 1);
    localparam logic [N_CH-1:0] ONE_CH   = {{(N_CH-1){1'b0}}, 1'b1};

    logic [MAX_OUTST-1:0] busy_q, busy_d;
    logic [CH_W-1:0]      slot_ch_q  [MAX_OUTST];
    logic [CH_W-1:0]      slot_ch_d  [MAX_OUTST];
    logic [CH_TAG_W-1:0]  slot_tag_q [MAX_OUTST];
    logic [CH_TAG_W-1:0]  slot_tag_d [MAX_OUTST];
    logic [CH_W-1:0]      last_gnt_q, last_gnt_d;
    logic                 mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [OPC_W-1:0]     opc_q, opc_d;
    logic [SLOT_W-1:0]    tag_q, tag_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [SLOT_W:0]      outstanding_q, outstanding_d;
    logic                 rsp_err_q, rsp_err_d;

    logic                 free_found;
    logic [SLOT_W-1:0]    free_slot;
    logic                 sel_found;
    logic [CH_W-1:0]      sel;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data;
    logic [OPC_W-1:0]     sel_opc;
    logic [CH_TAG_W-1:0]  sel_tag;
    logic                 can_issue;
    logic                 grant;
    logic                 rsp_hit;
    logic                 rsp_stray;

    // Lowest-index free slot, taken from the registered table so a slot being
    // freed this cycle only becomes allocatable next cycle.
    always_comb begin
        free_found = 1'b0;
        free_slot  = '0;
        for (int i = MAX_OUTST - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_slot  = SLOT_W'(i);
            end
        end
    end

    // Round-robin pick: first valid channel after last_gnt, wrapping at N_CH.
    always_comb begin
        logic [CH_W:0] cand;
        cand      = '0;
        sel_found = 1'b0;
        sel       = '0;
        for (int k = N_CH; k >= 1; k--) begin
            cand = {1'b0, last_gnt_q} + (CH_W+1)'(k);
            if (cand >= N_CH_V) begin
                cand = cand - N_CH_V;
            end
            if (bus.ch_req_valid[cand[CH_W-1:0]]) begin
                sel_found = 1'b1;
                sel       = cand[CH_W-1:0];
            end
        end
    end

    // Payload mux for the selected channel.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_opc  = '0;
        sel_tag  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel == CH_W'(i)) begin
                sel_addr = bus.ch_req_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.ch_req_store_data[i*DATA_W +: DATA_W];
                sel_opc  = bus.ch_req_opcode[i*OPC_W +: OPC_W];
                sel_tag  = bus.ch_req_tag[i*CH_TAG_W +: CH_TAG_W];
            end
        end
    end

    assign can_issue = (!mem_req_valid_q || bus.mem_req_ack) && free_found;
    assign grant     = !reset && can_issue && sel_found;
    assign rsp_hit   = !reset && bus.mem_rsp_valid && busy_q[bus.mem_rsp_tag];
    assign rsp_stray = !reset && bus.mem_rsp_valid && !busy_q[bus.mem_rsp_tag];

    // Next-state: slot table, output register, counters and sticky error.
    always_comb begin
        busy_d          = busy_q;
        slot_ch_d       = slot_ch_q;
        slot_tag_d      = slot_tag_q;
        last_gnt_d      = last_gnt_q;
        mem_req_valid_d = mem_req_valid_q;
        addr_d          = addr_q;
        data_d          = data_q;
        opc_d           = opc_q;
        tag_d           = tag_q;
        ch_d            = ch_q;
        rsp_err_d       = rsp_err_q | rsp_stray;

        if (rsp_hit) begin
            busy_d[bus.mem_rsp_tag] = 1'b0;
        end

        if (grant) begin
            busy_d[free_slot]     = 1'b1;
            slot_ch_d[free_slot]  = sel;
            slot_tag_d[free_slot] = sel_tag;
            last_gnt_d            = sel;
            mem_req_valid_d       = 1'b1;
            addr_d                = sel_addr;
            data_d                = sel_data;
            opc_d                 = sel_opc;
            tag_d                 = free_slot;
            ch_d                  = sel;
        end else if (bus.mem_req_ack) begin
            mem_req_valid_d = 1'b0;
        end

        outstanding_d = outstanding_q + {{SLOT_W{1'b0}}, grant} - {{SLOT_W{1'b0}}, rsp_hit};
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q          <= '0;
            last_gnt_q      <= LAST_RST;
            mem_req_valid_q <= 1'b0;
            addr_q          <= '0;
            data_q          <= '0;
            opc_q           <= '0;
            tag_q           <= '0;
            ch_q            <= '0;
            outstanding_q   <= '0;
            rsp_err_q       <= 1'b0;
            for (int i = 0; i < MAX_OUTST; i++) begin
                slot_ch_q[i]  <= '0;
                slot_tag_q[i] <= '0;
            end
        end else begin
            busy_q          <= busy_d;
            last_gnt_q      <= last_gnt_d;
            mem_req_valid_q <= mem_req_valid_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            opc_q           <= opc_d;
            tag_q           <= tag_d;
            ch_q            <= ch_d;
            outstanding_q   <= outstanding_d;
            rsp_err_q       <= rsp_err_d;
            slot_ch_q       <= slot_ch_d;
            slot_tag_q      <= slot_tag_d;
        end
    end

    assign bus.ch_req_ack         = grant ? (ONE_CH << sel) : '0;
    assign bus.ch_rsp_valid       = rsp_hit ? (ONE_CH << slot_ch_q[bus.mem_rsp_tag]) : '0;
    assign bus.ch_rsp_tag         = rsp_hit ? slot_tag_q[bus.mem_rsp_tag] : '0;
    assign bus.mem_req_valid      = mem_req_valid_q;
    assign bus.mem_req_addr       = addr_q;
    assign bus.mem_req_store_data = data_q;
    assign bus.mem_req_opcode     = opc_q;
    assign bus.mem_req_tag        = tag_q;
    assign bus.mem_req_ch         = ch_q;
    assign bus.outstanding        = outstanding_q;
    assign bus.idle               = (outstanding_q == '0) && !mem_req_valid_q;
    assign bus.rsp_err            = rsp_err_q;
endmodule

// File: tb/tb_mem_req_arbiter_n.sv
// Randomised scoreboard bench for mem_req_arbiter_n. A reference model built
// from slot arrays and a round-robin pointer predicts grants and responses and
// pushes them into queues; an independent monitor pops and compares whenever
// the DUT presents an ack, a response strobe or a downstream request.
module tb_mem_req_arbiter_n;
    localparam int N_CH      = 3;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 128;
    localparam int CH_TAG_W  = 2;
    localparam int OPC_W     = 5;
    localparam int MAX_OUTST = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_req_arbiter_n_if #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .CH_TAG_W(CH_TAG_W), .OPC_W(OPC_W), .MAX_OUTST(MAX_OUTST)
    ) bus ();

    mem_req_arbiter_n #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .CH_TAG_W(CH_TAG_W), .OPC_W(OPC_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int                ch;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [OPC_W-1:0]  opc;
        int                slot;
    } mreq_t;

    typedef struct {
        int ch;
        int tag;
    } rsp_t;

    mreq_t mem_q[$];
    rsp_t  rsp_q[$];
    int    ack_q[$];

    // requester-side stimulus state
    bit                rq_v    [N_CH];
    logic [ADDR_W-1:0] rq_addr [N_CH];
    logic [DATA_W-1:0] rq_data [N_CH];
    logic [OPC_W-1:0]  rq_opc  [N_CH];
    int                rq_tag  [N_CH];
    bit                granted [N_CH];

    // reference model
    bit m_busy [MAX_OUTST];
    int m_ch   [MAX_OUTST];
    int m_tag  [MAX_OUTST];
    int m_last;
    bit m_outv;
    bit m_err;

    int exp_outstanding;
    bit exp_outv, exp_idle, exp_err;
    bit mon_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int busy_count();
        int c = 0;
        for (int i = 0; i < MAX_OUTST; i++) c += m_busy[i] ? 1 : 0;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MAX_OUTST; i++) begin
            m_busy[i] = 1'b0;
            m_ch[i]   = 0;
            m_tag[i]  = 0;
        end
        for (int c = 0; c < N_CH; c++) granted[c] = 1'b0;
        m_last = N_CH - 1;
        m_outv = 1'b0;
        m_err  = 1'b0;
        mem_q.delete();
        rsp_q.delete();
        ack_q.delete();
    endtask

    // One cycle of the reference model, evaluated with this cycle's inputs.
    task automatic model_step(input bit rst, input bit mack, input bit rv, input int rtag);
        int cnt;
        int free_s;
        int sel;
        cnt = busy_count();
        exp_outstanding = cnt;
        exp_outv = m_outv;
        exp_idle = (cnt == 0) && !m_outv;
        exp_err  = m_err;
        if (rst) begin
            model_reset();
            return;
        end
        free_s = -1;
        for (int i = 0; i < MAX_OUTST; i++) if (free_s < 0 && !m_busy[i]) free_s = i;
        sel = -1;
        if ((!m_outv || mack) && free_s >= 0) begin
            for (int k = 1; k <= N_CH; k++) begin
                if (sel < 0 && rq_v[(m_last + k) % N_CH]) sel = (m_last + k) % N_CH;
            end
        end
        if (rv) begin
            if (m_busy[rtag]) begin
                rsp_q.push_back('{ch: m_ch[rtag], tag: m_tag[rtag]});
                m_busy[rtag] = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        if (sel >= 0) begin
            ack_q.push_back(sel);
            mem_q.push_back('{ch: sel, addr: rq_addr[sel], data: rq_data[sel],
                              opc: rq_opc[sel], slot: free_s});
            m_busy[free_s] = 1'b1;
            m_ch[free_s]   = sel;
            m_tag[free_s]  = rq_tag[sel];
            m_last         = sel;
            m_outv         = 1'b1;
            granted[sel]   = 1'b1;
        end else if (mack) begin
            m_outv = 1'b0;
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, then run the model.
    task automatic cycle(input int p_req, input int p_mack, input int p_rsp,
                         input int p_stray, input bit rst, input int force_slot);
        bit mack;
        bit rv;
        int rtag;
        int busy_list[$];
        @(negedge clk);
        for (int c = 0; c < N_CH; c++) begin
            if (granted[c]) rq_v[c] = 1'b0;
            granted[c] = 1'b0;
            if (!rq_v[c] && int'($urandom_range(99)) < p_req) begin
                rq_v[c]    = 1'b1;
                rq_addr[c] = $urandom;
                rq_data[c] = {$urandom, $urandom, $urandom, $urandom};
                rq_opc[c]  = OPC_W'($urandom);
                rq_tag[c]  = int'($urandom_range((1 << CH_TAG_W) - 1));
            end
            bus.ch_req_valid[c]                           = rq_v[c];
            bus.ch_req_addr[c*ADDR_W +: ADDR_W]           = rq_addr[c];
            bus.ch_req_store_data[c*DATA_W +: DATA_W]     = rq_data[c];
            bus.ch_req_opcode[c*OPC_W +: OPC_W]           = rq_opc[c];
            bus.ch_req_tag[c*CH_TAG_W +: CH_TAG_W]        = CH_TAG_W'(rq_tag[c]);
        end
        mack = int'($urandom_range(99)) < p_mack;
        rv   = 1'b0;
        rtag = 0;
        for (int i = 0; i < MAX_OUTST; i++) if (m_busy[i]) busy_list.push_back(i);
        if (force_slot >= 0) begin
            rv   = 1'b1;
            rtag = force_slot;
        end else if (int'($urandom_range(99)) < p_rsp) begin
            if (busy_list.size() == 0 || int'($urandom_range(99)) < p_stray) begin
                rv   = (busy_list.size() == 0) ? (int'($urandom_range(99)) < p_stray) : 1'b1;
                rtag = int'($urandom_range(MAX_OUTST - 1));
            end else begin
                rv   = 1'b1;
                rtag = busy_list[$urandom_range(busy_list.size() - 1)];
            end
        end
        reset             = rst;
        bus.mem_req_ack   = mack;
        bus.mem_rsp_valid = rv;
        bus.mem_rsp_tag   = rtag[$clog2(MAX_OUTST)-1:0];
        #1;
        model_step(rst, mack, rv, rtag);
        mon_en = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the queued expectations each cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                logic [N_CH-1:0] ev;
                if (bus.ch_req_ack != '0 || ack_q.size() != 0) begin
                    ev = '0;
                    if (ack_q.size() != 0) ev[ack_q.pop_front()] = 1'b1;
                    check("ch_req_ack", 256'(bus.ch_req_ack), 256'(ev));
                end
                if (bus.ch_rsp_valid != '0 || rsp_q.size() != 0) begin
                    rsp_t r;
                    ev = '0;
                    r  = '{ch: 0, tag: 0};
                    if (rsp_q.size() != 0) begin
                        r = rsp_q.pop_front();
                        ev[r.ch] = 1'b1;
                    end
                    check("ch_rsp_valid", 256'(bus.ch_rsp_valid), 256'(ev));
                    check("ch_rsp_tag", 256'(bus.ch_rsp_tag), 256'(r.tag));
                end
                check("mem_req_valid", 256'(bus.mem_req_valid), 256'(exp_outv));
                if (bus.mem_req_valid && !reset) begin
                    if (mem_q.size() == 0) begin
                        check("mem_req_unexpected", 256'(1), 256'(0));
                    end else begin
                        check("mem_req_addr", 256'(bus.mem_req_addr), 256'(mem_q[0].addr));
                        check("mem_req_store_data", 256'(bus.mem_req_store_data), 256'(mem_q[0].data));
                        check("mem_req_opcode", 256'(bus.mem_req_opcode), 256'(mem_q[0].opc));
                        check("mem_req_tag", 256'(bus.mem_req_tag), 256'(mem_q[0].slot));
                        check("mem_req_ch", 256'(bus.mem_req_ch), 256'(mem_q[0].ch));
                        if (bus.mem_req_ack) void'(mem_q.pop_front());
                    end
                end
                check("outstanding", 256'(bus.outstanding), 256'(exp_outstanding));
                check("idle", 256'(bus.idle), 256'(exp_idle));
                check("rsp_err", 256'(bus.rsp_err), 256'(exp_err));
            end
        end
    end

    // Stimulus phases: light traffic, saturation, full table, backpressure,
    // stray responses, mid-operation reset, then mixed random traffic.
    initial begin
        reset                 = 1'b1;
        bus.ch_req_valid      = '0;
        bus.ch_req_addr       = '0;
        bus.ch_req_store_data = '0;
        bus.ch_req_tag        = '0;
        bus.ch_req_opcode     = '0;
        bus.mem_req_ack       = 1'b0;
        bus.mem_rsp_valid     = 1'b0;
        bus.mem_rsp_tag       = '0;
        for (int c = 0; c < N_CH; c++) begin
            rq_v[c] = 1'b0; rq_addr[c] = '0; rq_data[c] = '0; rq_opc[c] = '0; rq_tag[c] = 0;
        end
        model_reset();

        repeat (3) cycle(0, 0, 0, 0, 1'b1, -1);
        repeat (200) cycle(30, 80, 40, 0, 1'b0, -1);
        repeat (200) cycle(100, 100, 100, 0, 1'b0, -1);
        repeat (20) cycle(100, 100, 0, 0, 1'b0, -1);
        cycle(100, 100, 0, 0, 1'b0, 2);
        repeat (10) cycle(100, 100, 0, 0, 1'b0, -1);
        repeat (150) cycle(60, 20, 30, 0, 1'b0, -1);
        repeat (100) cycle(50, 70, 40, 15, 1'b0, -1);
        repeat (2) cycle(50, 70, 0, 0, 1'b1, -1);
        repeat (50) cycle(50, 70, 50, 50, 1'b0, -1);
        for (int blk = 0; blk < 24; blk++) begin
            int pr, pm, ps, pst;
            pr  = int'($urandom_range(100));
            pm  = int'($urandom_range(100));
            ps  = int'($urandom_range(100));
            pst = int'($urandom_range(20));
            repeat (50) cycle(pr, pm, ps, pst, 1'b0, -1);
            if ($urandom_range(3) == 0) cycle(pr, pm, 0, 0, 1'b1, -1);
        end

        #5;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_req_arbiter_n.md
Name: mem_req_arbiter_n

Overview:
N-channel arbiter that merges cache-line memory requests from several requesters (L1I, L1D, prefetchers, etc.) onto one memory port. It is the parametrised successor to the fixed two-way L1D/L1I grant FSM. Channels are granted round-robin, and up to MAX_OUTST requests can be outstanding at once. Each request gets a downstream slot tag; responses are routed back by tag and the requester's original tag is restored.

Parameters:
N_CH, 2, number of requester channels (2..8)
ADDR_W, 32, request address width
DATA_W, 128, cache-line store data width
CH_TAG_W, 2, requester-side tag width
OPC_W, 5, opcode width
MAX_OUTST, 4, in-flight slots (power of 2, >=2); SLOT_W = log2(MAX_OUTST)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ch_req_valid  in  N_CH  per-channel request valid (level, held until ack)
ch_req_ack  out  N_CH  one-hot grant pulse; payload captured at this edge
ch_req_addr  in  N_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
ch_req_store_data  in  N_CH*DATA_W  packed store data
ch_req_tag  in  N_CH*CH_TAG_W  packed requester tags
ch_req_opcode  in  N_CH*OPC_W  packed opcodes
ch_rsp_valid  out  N_CH  one-hot response strobe
ch_rsp_tag  out  CH_TAG_W  restored requester tag (shared)
mem_req_valid  out  1  downstream request valid
mem_req_ack  in  1  downstream accepts request
mem_req_addr  out  ADDR_W  registered address
mem_req_store_data  out  DATA_W  registered store data
mem_req_opcode  out  OPC_W  registered opcode
mem_req_tag  out  SLOT_W  allocated slot index
mem_req_ch  out  max(1,log2 N_CH)  source channel of current request
mem_rsp_valid  in  1  response valid
mem_rsp_tag  in  SLOT_W  slot of response
outstanding  out  SLOT_W+1  busy slot count
idle  out  1  no busy slots and no valid output request
rsp_err  out  1  sticky: response hit a free slot

Behaviour:
- Reset values:
  - All outputs 0 except idle = 1.
  - Slot table all free.
  - Round-robin pointer last_gnt = N_CH-1, so channel 0 wins first.
  - Reset mid-operation drops queued and in-flight state. Later stale responses set rsp_err.
- Output stage is a single register.
  - can_issue = (!mem_req_valid || mem_req_ack) && at least one free slot.
- Grant:
  - If can_issue and any ch_req_valid, pick the first valid channel scanning from last_gnt+1 modulo N_CH.
  - ch_req_ack[sel] = 1 combinationally in that cycle.
  - At the edge: capture payload into the output register and set mem_req_valid = 1.
  - mem_req_tag = lowest-index free slot; mem_req_ch = sel; last_gnt = sel.
  - Mark the slot busy and store {ch, ch_req_tag}.
  - Back-to-back grants are allowed: 1 request per cycle when mem_req_ack is held high.
- Downstream handshake:
  - mem_req_valid and payload stay stable until mem_req_ack.
  - mem_req_valid clears on ack unless a new grant occurs in the same cycle.
- Response:
  - On mem_rsp_valid with busy slot s: in the same cycle, ch_rsp_valid[slot.ch] = 1 and ch_rsp_tag = slot.tag. Slot s frees at the edge.
  - Response to a free slot: no ch_rsp_valid; rsp_err set (sticky until reset).
- Simultaneous free and allocate in one cycle: the slot being freed is not eligible for allocation until the next cycle.
- A response may arrive while its own request is still in the output register (mem_req_ack not yet seen). This is legal and handled identically.
- outstanding = busy slot count, updated at the edge (+1 on grant, -1 on valid free, net 0 when both occur).
- Full: when all MAX_OUTST slots are busy, ch_req_ack stays 0; valid channels wait and are not reordered.
- Fairness: a continuously requesting channel waits at most N_CH-1 grants.
- idle = (outstanding == 0) && !mem_req_valid.

Test Plan:
- Single request: N_CH=2, reset, ch0 requests addr 0x1000 tag 2 with mem_req_ack=1 -> ack[0] in cycle 0; mem_req_valid=1 with slot 0 in cycle 1; rsp tag 0 -> ch_rsp_valid=2'b01, ch_rsp_tag=2, outstanding returns to 0, idle=1.
- Fairness: N_CH=3, all channels continuously valid, mem_req_ack=1, responses immediate -> grant order 0,1,2,0,1,2; no channel skipped.
- Full table: MAX_OUTST=4, no responses -> 4 grants using slots 0,1,2,3, then ch_req_ack=0 and outstanding=4. Response slot 2 -> next grant reuses slot 2 one cycle later, not in the same cycle.
- Backpressure: mem_req_ack=0 for 5 cycles -> payload stable, no further acks. mem_req_ack=1 -> next grant issues the same cycle.
- Out-of-order responses: slots 0,1,2 from ch1,ch0,ch1, responded in order 2,0,1 -> strobes ch1,ch0,ch1 with the original tags.
- Error/reset: response to free slot 3 -> no strobe, rsp_err=1. Reset with 2 in flight -> outstanding=0, idle=1, rsp_err=0.
